// File: rtl/frame_commit_fifo.sv
// Store-and-forward byte FIFO: frames are written speculatively and only
// become visible to the read side once their tlast beat arrives clean.
module frame_commit_fifo #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_bad,
    output logic [CNT_W-1:0] cnt_ovf
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_OCC = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [8:0]      r_mem [DEPTH];
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_commit_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_drop;

    logic [ADDR_W:0] w_occ;
    logic [ADDR_W:0] w_wr_next;
    logic            w_full;
    logic            w_wr_en;
    logic            w_avail;
    logic            w_load;

    assign s_axis_tready = 1'b1;

    // Full uses the registered read pointer, so a same-cycle read frees nothing.
    assign w_occ     = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_occ == FULL_OCC);
    assign w_wr_next = r_wr_ptr + 1'b1;
    assign w_wr_en   = s_axis_tvalid && !w_full && !r_drop;
    assign w_avail   = (r_rd_ptr != r_commit_ptr);
    assign w_load    = (!m_axis_tvalid || m_axis_tready) && w_avail;

    // Writes only ever land above the committed region, so rewinds are safe.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_drop       <= 1'b0;
            cnt_ok       <= '0;
            cnt_bad      <= '0;
            cnt_ovf      <= '0;
        end else if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
                r_drop <= 1'b0;
                if (s_axis_tuser) begin
                    r_wr_ptr <= r_commit_ptr;
                    if (cnt_bad != CNT_MAX) cnt_bad <= cnt_bad + 1'b1;
                end else if (r_drop || w_full) begin
                    r_wr_ptr <= r_commit_ptr;
                    if (cnt_ovf != CNT_MAX) cnt_ovf <= cnt_ovf + 1'b1;
                end else begin
                    r_wr_ptr     <= w_wr_next;
                    r_commit_ptr <= w_wr_next;
                    if (cnt_ok != CNT_MAX) cnt_ok <= cnt_ok + 1'b1;
                end
            end else if (w_wr_en) begin
                r_wr_ptr <= w_wr_next;
            end else begin
                r_drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (w_load) begin
            {m_axis_tlast, m_axis_tdata} <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            r_rd_ptr      <= r_rd_ptr + 1'b1;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule
